// File: rtl/manual_trigger_debounce_pkg.sv
// Shared definitions for panel-key debouncing: FSM state encoding and the
// default qualification time used by all panel-key front ends.
package manual_trigger_debounce_pkg;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    IDLE_HIGH = 2'b00,
    WAIT_LOW  = 2'b01,
    IDLE_LOW  = 2'b10,
    WAIT_HIGH = 2'b11
  } deb_state_e;

  function automatic logic is_wait(input deb_state_e st);
    return (st == WAIT_LOW) || (st == WAIT_HIGH);
  endfunction

endpackage

// File: rtl/manual_trigger_debounce_channel.sv
// One key: reset-to-1 synchroniser, four-state debounce FSM and stable-time
// counter. The output is its own register so it can never glitch on decode.
module debounce_channel
  import manual_trigger_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic key_i,
  output logic out_o,
  output logic busy_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   s;

  // Synchroniser is never gated by the enable so s is valid on re-enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    if (!en_i) begin
      state_d = IDLE_HIGH;
      cnt_d   = '0;
      out_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE_HIGH: begin
          if (!s) begin
            state_d = WAIT_LOW;
            cnt_d   = '0;
          end
        end
        WAIT_LOW: begin
          if (s)                    state_d = IDLE_HIGH;
          else if (cnt_q == CNT_LAST) begin
            state_d = IDLE_LOW;
            out_d   = 1'b0;
          end else                  cnt_d = cnt_q + 1'b1;
        end
        IDLE_LOW: begin
          if (s) begin
            state_d = WAIT_HIGH;
            cnt_d   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s)                   state_d = IDLE_LOW;
          else if (cnt_q == CNT_LAST) begin
            state_d = IDLE_HIGH;
            out_d   = 1'b1;
          end else                  cnt_d = cnt_q + 1'b1;
        end
        default: begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          out_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE_HIGH;
      cnt_q   <= '0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = is_wait(state_q);

endmodule

// File: rtl/manual_trigger_debounce.sv
// Manual trigger key front end: two independent debounced active-low keys
// plus a registered busy flag covering either channel's qualification window.
module manual_trigger_debounce
  import manual_trigger_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Key_Ain,
  input  logic Key_Bin,
  input  logic MNTrig_EN,
  output logic Trig_Aout,
  output logic Trig_Bout,
  output logic Trig_Busy
);

  logic busy_a, busy_b;
  logic busy_q, busy_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_chan_a (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .en_i   (MNTrig_EN),
    .key_i  (Key_Ain),
    .out_o  (Trig_Aout),
    .busy_o (busy_a)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_chan_b (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .en_i   (MNTrig_EN),
    .key_i  (Key_Bin),
    .out_o  (Trig_Bout),
    .busy_o (busy_b)
  );

  // Gated by the enable so busy drops on the same edge the FSMs are forced idle.
  assign busy_d = MNTrig_EN & (busy_a | busy_b);

  always_ff @(posedge Clock) begin
    if (Reset) busy_q <= 1'b0;
    else       busy_q <= busy_d;
  end

  assign Trig_Busy = busy_q;

endmodule
